// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Each digit slot opens with one dead-time cycle (all anodes off).
// New character data is committed only at frame boundaries, so a frame is
// never torn between old and new data. AN, LED and frame_done are registered.
//
// Optional build macro:
//   SEG7_LZB_EN - leading-zero blanking. A zero in digit i > 0 is shown blank
//                 when every higher digit is 0 or a blank code (B..E).
//                 Digit 0 always shows its code.
module seg7_scan_driver #(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   data_in,
    output logic [N_DIGITS-1:0]     AN,
    output logic [6:0]              LED,
    output logic                    frame_done
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
    localparam logic [4*N_DIGITS-1:0] DISP_RESET = {N_DIGITS{4'hB}};

    // Character code to active-low segment pattern (LED[6]=g .. LED[0]=a)
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0111111;
            4'hF:    seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [4*N_DIGITS-1:0]  r_disp;
    logic [4*N_DIGITS-1:0]  r_pend;
    logic                   r_pflag;
    logic                   r_wrap;
    logic [N_DIGITS-1:0]    r_an;
    logic [6:0]             r_led;
    logic                   r_frame_done;

    logic                   w_slot_end;
    logic                   w_frame_end;
    logic [3:0]             w_code;
    logic                   w_blank_sel;
    logic [N_DIGITS-1:0]    w_blank_vec;
    logic [N_DIGITS-1:0]    w_an_nxt;
    logic [6:0]             w_led_nxt;

    assign w_slot_end  = (r_cnt == CNT_MAX);
    assign w_frame_end = w_slot_end && (r_idx == IDX_MAX);

`ifdef SEG7_LZB_EN
    logic w_above_ok;

    // Mark digits that are leading zeros, walking down from the top digit
    always_comb begin
        w_blank_vec = '0;
        w_above_ok  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (w_above_ok && (r_disp[4*i +: 4] == 4'h0)) begin
                w_blank_vec[i] = 1'b1;
            end else begin
                w_blank_vec[i] = 1'b0;
            end
            if ((r_disp[4*i +: 4] == 4'h0) || (r_disp[4*i +: 4] >= 4'hB && r_disp[4*i +: 4] <= 4'hE)) begin
                w_above_ok = w_above_ok;
            end else begin
                w_above_ok = 1'b0;
            end
        end
    end
`else
    assign w_blank_vec = '0;
`endif

    // Select the character code and blanking flag of the digit being scanned
    always_comb begin
        w_code      = 4'hB;
        w_blank_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_code      = r_disp[4*i +: 4];
                w_blank_sel = w_blank_vec[i];
            end else begin
                w_code      = w_code;
                w_blank_sel = w_blank_sel;
            end
        end
    end

    // Next anode/segment values: dark in dead time or when disabled
    always_comb begin
        w_an_nxt  = '1;
        w_led_nxt = 7'h7F;
        if (enable && (r_cnt != '0)) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                w_an_nxt[i] = (r_idx == IW'(i)) ? 1'b0 : 1'b1;
            end
            w_led_nxt = w_blank_sel ? 7'h7F : seg_decode(w_code);
        end else begin
            w_an_nxt  = '1;
            w_led_nxt = 7'h7F;
        end
    end

    // Scan counters and tear-free display data handoff
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_disp  <= DISP_RESET;
            r_pend  <= '0;
            r_pflag <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (!enable) begin
            // No frame in progress: data can go straight to the display
            r_cnt  <= '0;
            r_idx  <= '0;
            r_wrap <= 1'b0;
            if (load) begin
                r_disp  <= data_in;
                r_pend  <= data_in;
                r_pflag <= 1'b0;
            end else if (r_pflag) begin
                r_disp  <= r_pend;
                r_pflag <= 1'b0;
            end else begin
                r_pflag <= 1'b0;
            end
        end else begin
            r_cnt  <= w_slot_end ? '0 : (r_cnt + CW'(1));
            r_wrap <= w_frame_end;
            if (w_slot_end) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : (r_idx + IW'(1));
            end else begin
                r_idx <= r_idx;
            end
            // A load on the boundary itself wins over any older pending data
            if (w_frame_end && load) begin
                r_disp  <= data_in;
                r_pflag <= 1'b0;
            end else if (w_frame_end && r_pflag) begin
                r_disp  <= r_pend;
                r_pflag <= 1'b0;
            end else if (load) begin
                r_pend  <= data_in;
                r_pflag <= 1'b1;
            end else begin
                r_pflag <= r_pflag;
            end
        end
    end

    // Output registers; frame_done marks the dead cycle of digit 0 after a wrap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an         <= '1;
            r_led        <= 7'h7F;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_nxt;
            r_led        <= w_led_nxt;
            r_frame_done <= enable & r_wrap;
        end
    end

    assign AN         = r_an;
    assign LED        = r_led;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (N_DIGITS=4, PRESCALE=4).
// A cycle model pushes expected outputs to a queue at each rising edge; the
// queue is popped and compared on the falling edge. Table-driven frame checks
// and hand-written sequences cover tear-free update, boundary loads, enable
// gating and asynchronous reset. Expectations follow SEG7_LZB_EN if defined.
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0000;
    logic [3:0]  AN;
    logic [6:0]  LED;
    logic        frame_done;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] led;
        logic       fd;
    } out_t;

    typedef struct packed {
        logic [15:0] data;
        logic [27:0] leds;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    out_t sb_q[$];

    logic [1:0]  m_cnt;
    logic [1:0]  m_idx;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    logic        m_pflag;
    logic        m_wrapped;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .N_DIGITS (N),
        .PRESCALE (P)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .AN         (AN),
        .LED        (LED),
        .frame_done (frame_done)
    );

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0111111;
            4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    function automatic out_t ref_out(input logic en, input logic [1:0] cnt,
                                     input logic [1:0] idx, input logic [15:0] disp,
                                     input logic wr);
        out_t o;
        logic [3:0] code;
        logic blank;
        o.an  = 4'hF;
        o.led = 7'h7F;
        o.fd  = en && (cnt == 2'd0) && (idx == 2'd0) && wr;
        if (en && (cnt != 2'd0)) begin
            o.an[idx] = 1'b0;
            code = disp[idx*4 +: 4];
            blank = 1'b0;
`ifdef SEG7_LZB_EN
            if ((idx != 2'd0) && (code == 4'h0)) begin
                blank = 1'b1;
                for (int j = int'(idx) + 1; j < N; j++) begin
                    if (!((disp[j*4 +: 4] == 4'h0) || (disp[j*4 +: 4] >= 4'hB && disp[j*4 +: 4] <= 4'hE)))
                        blank = 1'b0;
                end
            end
`endif
            o.led = blank ? 7'h7F : ref_seg(code);
        end
        return o;
    endfunction

    // Reference cycle model: predict next output, then advance state
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt     <= 2'd0;
            m_idx     <= 2'd0;
            m_disp    <= 16'hBBBB;
            m_pend    <= 16'h0000;
            m_pflag   <= 1'b0;
            m_wrapped <= 1'b0;
            sb_q.delete();
        end else begin
            sb_q.push_back(ref_out(enable, m_cnt, m_idx, m_disp, m_wrapped));
            if (!enable) begin
                m_cnt     <= 2'd0;
                m_idx     <= 2'd0;
                m_wrapped <= 1'b0;
                if (load) begin
                    m_disp  <= data_in;
                    m_pflag <= 1'b0;
                end else if (m_pflag) begin
                    m_disp  <= m_pend;
                    m_pflag <= 1'b0;
                end
            end else begin
                m_cnt <= m_cnt + 2'd1;
                if (m_cnt == 2'd3) m_idx <= m_idx + 2'd1;
                if (m_cnt == 2'd3 && m_idx == 2'd3) begin
                    m_wrapped <= 1'b1;
                    if (load) begin
                        m_disp  <= data_in;
                        m_pflag <= 1'b0;
                    end else if (m_pflag) begin
                        m_disp  <= m_pend;
                        m_pflag <= 1'b0;
                    end
                end else if (load) begin
                    m_pend  <= data_in;
                    m_pflag <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard check on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            chk("sb_reset", {20'd0, AN, LED, frame_done}, {20'd0, 4'hF, 7'h7F, 1'b0});
        end else if (sb_q.size() > 0) begin
            out_t e;
            e = sb_q.pop_front();
            chk("sb_out", {20'd0, AN, LED, frame_done}, {20'd0, e});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] c, input logic [1:0] i);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 64 && !hit; k++) begin
            step();
            if (m_cnt == c && m_idx == i) hit = 1'b1;
        end
        if (!hit) begin
            total_cnt++;
            $display("FAIL wait_state: timeout waiting for cnt=%0d idx=%0d", c, i);
        end
    endtask

    // Expects the next 16 outputs to be one full frame starting at digit 0's dead cycle
    task automatic expect_frame(input logic [27:0] leds, input logic fd0);
        logic [3:0] one;
        logic [3:0] e_an;
        logic [6:0] e_led;
        logic       e_fd;
        one = 4'b0001;
        for (int d = 0; d < N; d++) begin
            for (int c = 0; c < P; c++) begin
                step();
                e_an  = (c == 0) ? 4'hF : ~(one << d);
                e_led = (c == 0) ? 7'h7F : leds[d*7 +: 7];
                e_fd  = (d == 0 && c == 0) ? fd0 : 1'b0;
                chk("frame_an",  {28'd0, AN},  {28'd0, e_an});
                chk("frame_led", {25'd0, LED}, {25'd0, e_led});
                chk("frame_fd",  {31'd0, frame_done}, {31'd0, e_fd});
            end
        end
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{16'h9FA5, {7'b0010000, 7'b0001110, 7'b0111111, 7'b0010010}};
        vecs[1] = '{16'h3210, {7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}};
        vecs[2] = '{16'h7654, {7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001}};
        vecs[3] = '{16'hEDCB, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}};
        vecs[5] = '{16'h8A08, {7'b0000000, 7'b0111111, 7'b1000000, 7'b0000000}};
`ifdef SEG7_LZB_EN
        vecs[4] = '{16'h0070, {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000}};
        vecs[6] = '{16'h0B01, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111001}};
`else
        vecs[4] = '{16'h0070, {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}};
        vecs[6] = '{16'h0B01, {7'b1000000, 7'b1111111, 7'b1000000, 7'b1111001}};
`endif

        // Reset state
        step();
        step();
        chk("reset_an",  {28'd0, AN},  {28'd0, 4'hF});
        chk("reset_led", {25'd0, LED}, {25'd0, 7'h7F});
        chk("reset_fd",  {31'd0, frame_done}, 32'd0);
        reset = 1'b0;

        // Blank display after reset
        wait_state(2'd0, 2'd0);
        expect_frame({4{7'h7F}}, 1'b1);

        // Character map and blanking, one table row per frame
        for (int v = 0; v < 7; v++) begin
            wait_state(2'd1, 2'd1);
            load = 1'b1;
            data_in = vecs[v].data;
            step();
            load = 1'b0;
            wait_state(2'd0, 2'd0);
            expect_frame(vecs[v].leds, 1'b1);
        end

        // Tear-free update: two loads in one frame, only the latest is shown
        wait_state(2'd1, 2'd2);
        load = 1'b1;
        data_in = 16'h1234;
        step();
        load = 1'b0;
        wait_state(2'd1, 2'd3);
        load = 1'b1;
        data_in = 16'h5678;
        step();
        load = 1'b0;
        wait_state(2'd0, 2'd0);
        expect_frame({7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 1'b1);

        // Load on the frame boundary overrides a stale pending load
        wait_state(2'd1, 2'd1);
        load = 1'b1;
        data_in = 16'h1111;
        step();
        load = 1'b0;
        wait_state(2'd3, 2'd3);
        load = 1'b1;
        data_in = 16'h4321;
        step();
        load = 1'b0;
        expect_frame({7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}, 1'b1);
        expect_frame({7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}, 1'b1);

        // Enable gating with a direct load while dark
        wait_state(2'd2, 2'd1);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("dis_an",  {28'd0, AN},  {28'd0, 4'hF});
            chk("dis_led", {25'd0, LED}, {25'd0, 7'h7F});
            chk("dis_fd",  {31'd0, frame_done}, 32'd0);
            if (k == 4) begin
                load = 1'b1;
                data_in = 16'h0123;
            end else begin
                load = 1'b0;
            end
        end
        enable = 1'b1;
`ifdef SEG7_LZB_EN
        expect_frame({7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000}, 1'b0);
        expect_frame({7'b1111111, 7'b1111001, 7'b0100100, 7'b0110000}, 1'b1);
`else
        expect_frame({7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000}, 1'b0);
        expect_frame({7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000}, 1'b1);
`endif

        // Asynchronous reset in the middle of a lit slot
        wait_state(2'd2, 2'd1);
        chk("prerst_an", {28'd0, AN}, {28'd0, 4'b1101});
        #2;
        reset = 1'b1;
        #1;
        chk("async_an",  {28'd0, AN},  {28'd0, 4'hF});
        chk("async_led", {25'd0, LED}, {25'd0, 7'h7F});
        chk("async_fd",  {31'd0, frame_done}, 32'd0);
        step();
        reset = 1'b0;
        wait_state(2'd0, 2'd0);
        expect_frame({4{7'h7F}}, 1'b1);

        step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
